pipeline_run_controller: RTL and testbench
==========================================

Name: pipeline_run_controller

Overview:
- Sequences the MIPS pipeline, starting at the fetch stage.
- Decides each cycle whether the pipeline advances: continuous run, single step, or stopped.
- Detects load-use hazards and issues stall; converts taken branches into flush/PC-select.
- On a fetched HALT, drains the remaining stages and reports completion to the debug unit.

Parameters:
- NB_REG, 5, register index width
- NB_CYCLES, 32, width of executed-cycle counter
- PIPE_DEPTH, 5, pipeline stages; drain length = PIPE_DEPTH-1 cycles

Ports:
- i_clock  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_cmd_valid  input  1  command strobe from debug unit
- i_cmd  input  2  00 nop, 01 run, 10 step, 11 stop
- i_halt_fetched  input  1  fetch stage holds a HALT instruction
- i_branch_taken  input  1  branch/jump resolved taken this cycle
- i_ex_mem_read  input  1  instruction in EX is a load
- i_ex_rt  input  NB_REG  load destination in EX
- i_id_rs  input  NB_REG  rs of instruction in ID
- i_id_rt  input  NB_REG  rt of instruction in ID
- o_cmd_ready  output  1  command accepted this cycle if valid
- o_valid  output  1  pipeline advance enable (fetch i_valid)
- o_stall  output  1  hold PC and IF/ID, bubble into ID/EX
- o_flush  output  1  squash IF/ID
- o_pc_src  output  1  select branch target PC
- o_halt  output  1  freeze PC (fetch i_halt)
- o_done  output  1  program finished and drained
- o_state  output  3  current FSM state
- o_cycle_count  output  NB_CYCLES  cycles with o_valid=1

Behaviour:
- States (o_state encoding): IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. FSM and counters are registered.
- Reset values: state IDLE, all 1-bit outputs 0 except o_cmd_ready=1, o_cycle_count=0, drain counter 0.
- Reset is asynchronous: asserting it mid-run or mid-drain returns to IDLE immediately.
- o_cmd_ready is 1 in IDLE and RUN, 0 elsewhere. A command with i_cmd_valid=1 and o_cmd_ready=0 is dropped, with no effect.
- IDLE transitions: run goes to RUN; step goes to STEP; stop and nop stay in IDLE.
- RUN: o_valid=1 every cycle. A stop command returns to IDLE next cycle. A step command in RUN is ignored.
- STEP: o_valid=1 for exactly one cycle, then IDLE (unless HALT is taken, below).
- o_valid=0 in IDLE and HALTED. o_valid=1 in RUN, STEP and DRAIN.
- Hazard detection (combinational):
  - haz = i_ex_mem_read && (i_ex_rt != 0) && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt).
  - o_stall = haz && o_valid && !i_branch_taken.
- Branch handling (combinational): o_flush = o_pc_src = i_branch_taken && o_valid. Branch has priority over stall.
- HALT entry: in RUN or STEP, when i_halt_fetched && !i_branch_taken && !o_stall:
  - next state DRAIN; drain counter loads PIPE_DEPTH-1.
  - HALT together with a taken branch is ignored (it will be squashed).
  - HALT while stalled is re-evaluated next cycle.
- DRAIN:
  - o_halt=1 and o_valid=1; counter decrements each cycle.
  - When the counter reaches 1, next state is HALTED. DRAIN lasts exactly PIPE_DEPTH-1 cycles.
  - Commands are ignored.
- HALTED: o_done=1, o_halt=1, o_valid=0. Exit only via reset.
- o_done and o_halt are registered from state; both are 0 outside DRAIN/HALTED, except o_halt=1 in DRAIN.
- o_cycle_count increments every cycle o_valid=1, including stall and drain cycles. It saturates at 2^NB_CYCLES-1 and does not wrap.
- A stall cycle in STEP counts as the step; the stalled instruction needs another step.

Test Plan:
- Reset, then cmd run for 1 cycle, 10 cycles free -> o_valid=1 from the cycle after the command, o_cycle_count=10, o_state=1; cmd stop -> IDLE, o_valid=0 next cycle.
- From IDLE, three step commands spaced 4 cycles apart -> exactly 3 single-cycle o_valid pulses, o_cycle_count=3; a step sent while in STEP is dropped (o_cmd_ready=0).
- RUN with i_ex_mem_read=1, i_ex_rt=8, i_id_rs=8 -> o_stall=1 that cycle. Same with i_ex_rt=0 -> o_stall=0. Add i_branch_taken=1 -> o_stall=0, o_flush=o_pc_src=1.
- RUN, raise i_halt_fetched -> DRAIN for exactly 4 cycles with o_halt=1, o_valid=1, then HALTED with o_done=1, o_valid=0. Run/step commands there have no effect.
- i_halt_fetched and i_branch_taken together in RUN -> stays in RUN, o_flush=1. i_halt_fetched together with a hazard -> DRAIN entered one cycle later.
- Assert i_reset during DRAIN (count 2) -> asynchronously IDLE, o_halt=0, o_cycle_count=0. NB_CYCLES=4 run for 20 cycles -> count saturates at 15.

Source files
------------

// File: rtl/pipeline_run_controller.sv
// Run/step/stop sequencer for the MIPS pipeline: advance enable, load-use stall,
// branch flush, and HALT drain with completion report to the debug unit.
module pipeline_run_controller #(
  parameter int NB_REG     = 5,
  parameter int NB_CYCLES  = 32,
  parameter int PIPE_DEPTH = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  input  logic                 i_halt_fetched,
  input  logic                 i_branch_taken,
  input  logic                 i_ex_mem_read,
  input  logic [NB_REG-1:0]    i_ex_rt,
  input  logic [NB_REG-1:0]    i_id_rs,
  input  logic [NB_REG-1:0]    i_id_rt,
  output logic                 o_cmd_ready,
  output logic                 o_valid,
  output logic                 o_stall,
  output logic                 o_flush,
  output logic                 o_pc_src,
  output logic                 o_halt,
  output logic                 o_done,
  output logic [2:0]           o_state,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  localparam int NB_DRAIN = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(PIPE_DEPTH - 1);

  state_t              state;
  state_t              state_next;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic                haz;
  logic                halt_take;
  logic                cmd_accept;

  assign o_state = state;

  // Branch wins over stall: the instruction that would stall is being squashed.
  always_comb begin
    haz        = i_ex_mem_read && (i_ex_rt != '0) &&
                 ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    o_stall    = haz && o_valid && !i_branch_taken;
    o_flush    = i_branch_taken && o_valid;
    o_pc_src   = i_branch_taken && o_valid;
    halt_take  = i_halt_fetched && !i_branch_taken && !o_stall;
    cmd_accept = i_cmd_valid && o_cmd_ready;
  end

  // NOTE: next-state defaults to the current state first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_accept && i_cmd == CMD_RUN)       state_next = ST_RUN;
        else if (cmd_accept && i_cmd == CMD_STEP) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (halt_take)                            state_next = ST_DRAIN;
        else if (cmd_accept && i_cmd == CMD_STOP) state_next = ST_IDLE;
      end
      ST_STEP:   state_next = halt_take ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:  if (drain_cnt == NB_DRAIN'(1)) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // NOTE: all state and registered outputs use non-blocking assignment so every
  // flop samples pre-edge values; outputs are decoded from the next state so
  // they change in the same cycle as o_state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      drain_cnt     <= '0;
      o_cmd_ready   <= 1'b1;
      o_valid       <= 1'b0;
      o_halt        <= 1'b0;
      o_done        <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state       <= state_next;
      o_cmd_ready <= (state_next == ST_IDLE) || (state_next == ST_RUN);
      o_valid     <= (state_next == ST_RUN) || (state_next == ST_STEP) ||
                     (state_next == ST_DRAIN);
      o_halt      <= (state_next == ST_DRAIN) || (state_next == ST_HALTED);
      o_done      <= (state_next == ST_HALTED);

      if (state != ST_DRAIN && state_next == ST_DRAIN) drain_cnt <= DRAIN_LOAD;
      else if (state == ST_DRAIN)                      drain_cnt <= drain_cnt - NB_DRAIN'(1);

      // Saturating count of advance cycles, stall and drain cycles included.
      if (o_valid && (o_cycle_count != '1)) o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: per-cycle comparison against a
// behavioural model, plus literal checkpoints; a 4-bit-counter instance covers saturation.
module tb_pipeline_run_controller;

  localparam int PIPE_DEPTH = 5;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic [1:0] i_cmd = 2'b00;
  logic       i_halt_fetched = 1'b0;
  logic       i_branch_taken = 1'b0;
  logic       i_ex_mem_read = 1'b0;
  logic [4:0] i_ex_rt = '0, i_id_rs = '0, i_id_rt = '0;

  logic        a_ready, a_valid, a_stall, a_flush, a_pc_src, a_halt, a_done;
  logic [2:0]  a_state;
  logic [31:0] a_count;
  logic        b_ready, b_valid, b_stall, b_flush, b_pc_src, b_halt, b_done;
  logic [2:0]  b_state;
  logic [3:0]  b_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_run_controller #(.NB_REG(5), .NB_CYCLES(32), .PIPE_DEPTH(PIPE_DEPTH)) dut_a (
    .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_halt_fetched(i_halt_fetched), .i_branch_taken(i_branch_taken),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .o_cmd_ready(a_ready), .o_valid(a_valid), .o_stall(a_stall), .o_flush(a_flush),
    .o_pc_src(a_pc_src), .o_halt(a_halt), .o_done(a_done), .o_state(a_state),
    .o_cycle_count(a_count));

  pipeline_run_controller #(.NB_REG(5), .NB_CYCLES(4), .PIPE_DEPTH(PIPE_DEPTH)) dut_b (
    .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_halt_fetched(i_halt_fetched), .i_branch_taken(i_branch_taken),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .o_cmd_ready(b_ready), .o_valid(b_valid), .o_stall(b_stall), .o_flush(b_flush),
    .o_pc_src(b_pc_src), .o_halt(b_halt), .o_done(b_done), .o_state(b_state),
    .o_cycle_count(b_count));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a few flags describing what the pipeline is doing.
  bit      m_run = 0, m_step = 0, m_halted = 0;
  int      m_drain_left = 0;
  longint  m_cnt_a = 0, m_cnt_b = 0;

  function automatic bit m_valid();
    return m_run || m_step || (m_drain_left > 0);
  endfunction
  function automatic bit m_haz();
    return i_ex_mem_read && (i_ex_rt != 0) && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
  endfunction
  function automatic bit m_stall();
    return m_haz() && m_valid() && !i_branch_taken;
  endfunction
  function automatic bit m_flush();
    return i_branch_taken && m_valid();
  endfunction
  function automatic bit m_ready();
    return !m_step && (m_drain_left == 0) && !m_halted;
  endfunction
  function automatic int m_state();
    if (m_halted) return 4;
    if (m_drain_left > 0) return 3;
    if (m_step) return 2;
    if (m_run) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      m_run = 0; m_step = 0; m_halted = 0; m_drain_left = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      bit v, st;
      v  = m_valid();
      st = m_stall();
      if (v) begin
        if (m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
      if (m_halted) begin
      end else if (m_drain_left > 0) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end else if ((m_run || m_step) && i_halt_fetched && !i_branch_taken && !st) begin
        m_run = 0; m_step = 0; m_drain_left = PIPE_DEPTH - 1;
      end else if (m_step) begin
        m_step = 0;
      end else if (m_run) begin
        if (i_cmd_valid && i_cmd == 2'b11) m_run = 0;
      end else if (i_cmd_valid) begin
        if (i_cmd == 2'b01) m_run = 1;
        else if (i_cmd == 2'b10) m_step = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("ready",  a_ready,  m_ready());
    check("valid",  a_valid,  m_valid());
    check("stall",  a_stall,  m_stall());
    check("flush",  a_flush,  m_flush());
    check("pc_src", a_pc_src, m_flush());
    check("halt",   a_halt,   (m_drain_left > 0) || m_halted);
    check("done",   a_done,   m_halted);
    check("state",  a_state,  m_state());
    check("count",  a_count,  m_cnt_a);
    check("b_state", b_state, m_state());
    check("b_count", b_count, m_cnt_b);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
  endtask

  task automatic cmd_clear();
    i_cmd_valid = 1'b0;
    i_cmd       = 2'b00;
  endtask

  task automatic hazard(input logic rd, input logic [4:0] ex_rt, input logic [4:0] rs,
                        input logic [4:0] rt);
    i_ex_mem_read = rd; i_ex_rt = ex_rt; i_id_rs = rs; i_id_rt = rt;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc(2);
    i_reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    #1;
    check("rst_state", a_state, 0);
    check("rst_ready", a_ready, 1);
    check("rst_valid", a_valid, 0);
    i_reset = 1'b0;
    cyc(1);

    // Run for 10 cycles, then stop.
    cmd(2'b01); cyc(1); cmd_clear();
    #1 check("run_valid0", a_valid, 1);
    cyc(10);
    #1 check("run_count10", a_count, 10);
    check("run_state", a_state, 1);
    cmd(2'b11); cyc(1); cmd_clear();
    #1 check("stop_state", a_state, 0);
    check("stop_valid", a_valid, 0);
    check("stop_count", a_count, 11);

    // Three steps; the first one keeps a second step asserted during STEP.
    for (int k = 0; k < 3; k++) begin
      cmd(2'b10); cyc(1);
      #1 check("step_ready", a_ready, 0);
      check("step_valid", a_valid, 1);
      if (k != 0) cmd_clear();
      cyc(1); cmd_clear();
      #1 check("step_back_idle", a_state, 0);
      cyc(2);
    end
    #1 check("step_count", a_count, 14);

    // Hazard and branch cases while running.
    cmd(2'b01); cyc(1); cmd_clear();
    hazard(1, 5'd8, 5'd8, 5'd3);
    #1 check("haz_rs_stall", a_stall, 1);
    cyc(1);
    hazard(1, 5'd9, 5'd0, 5'd9);
    #1 check("haz_rt_stall", a_stall, 1);
    cyc(1);
    hazard(1, 5'd0, 5'd0, 5'd0);
    #1 check("haz_r0_stall", a_stall, 0);
    cyc(1);
    hazard(1, 5'd8, 5'd8, 5'd3);
    i_branch_taken = 1'b1;
    #1 check("br_stall", a_stall, 0);
    check("br_flush", a_flush, 1);
    check("br_pc_src", a_pc_src, 1);
    cyc(1);
    hazard(0, 5'd0, 5'd0, 5'd0);

    // HALT with a taken branch is ignored; HALT with a hazard waits one cycle.
    i_halt_fetched = 1'b1;
    cyc(1);
    #1 check("halt_br_state", a_state, 1);
    i_branch_taken = 1'b0;
    hazard(1, 5'd8, 5'd8, 5'd3);
    cyc(1);
    #1 check("halt_haz_state", a_state, 1);
    hazard(0, 5'd0, 5'd0, 5'd0);
    cyc(1);
    i_halt_fetched = 1'b0;
    #1 check("drain_state", a_state, 3);
    check("drain_halt", a_halt, 1);
    check("drain_valid", a_valid, 1);
    cyc(3);
    #1 check("drain_last", a_state, 3);
    cyc(1);
    #1 check("halted_state", a_state, 4);
    check("halted_done", a_done, 1);
    check("halted_valid", a_valid, 0);
    cmd(2'b01); cyc(1);
    cmd(2'b10); cyc(1); cmd_clear();
    #1 check("halted_sticky", a_state, 4);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    cmd(2'b01); cyc(1); cmd_clear();
    i_halt_fetched = 1'b1; cyc(1); i_halt_fetched = 1'b0;
    cyc(2);
    i_reset = 1'b1;
    #1 check("async_state", a_state, 0);
    check("async_halt", a_halt, 0);
    check("async_count", a_count, 0);
    cyc(1);
    i_reset = 1'b0;
    cyc(1);

    // 20 run cycles: 4-bit instance saturates at 15.
    cmd(2'b01); cyc(1); cmd_clear();
    cyc(20);
    #1 check("sat_count_a", a_count, 20);
    check("sat_count_b", b_count, 15);
    cmd(2'b11); cyc(1); cmd_clear();
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
